// File: rtl/mrd_sink_if.sv
// rtl/mrd_sink_if.sv - sample stream into the DFT ingress stage.
interface mrd_sink_if #(
  parameter int DW    = 18,
  parameter int PTS_W = 12
);
  logic             in_valid;
  logic             in_sop;
  logic             in_eop;
  logic [DW-1:0]    in_real;
  logic [DW-1:0]    in_imag;
  logic [PTS_W-1:0] in_dftpts;
  logic             in_inverse;
  logic             in_ready;

  modport master (
    output in_valid, in_sop, in_eop, in_real, in_imag, in_dftpts, in_inverse,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_sop, in_eop, in_real, in_imag, in_dftpts, in_inverse,
    output in_ready
  );
endinterface

// File: rtl/mrd_sink.sv
// rtl/mrd_sink.sv - frame ingress: framing checks and scatter of samples into
// the 5-bank data memory (sample n -> bank n%NBANK, addr n/NBANK).
module mrd_sink #(
  parameter int DW      = 18,
  parameter int PTS_W   = 12,
  parameter int NBANK   = 5,
  parameter int AW      = 10,
  parameter int MAX_PTS = 1200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sink_en_i,
  mrd_sink_if.slave        st_i,
  output logic             wr_en_o,
  output logic [2:0]       wr_bank_o,
  output logic [AW-1:0]    wr_addr_o,
  output logic [DW-1:0]    wr_real_o,
  output logic [DW-1:0]    wr_imag_o,
  output logic [PTS_W-1:0] frm_dftpts_o,
  output logic             frm_inverse_o,
  output logic             frame_done_o,
  output logic             frm_err_o
);

  typedef enum logic [1:0] {IDLE, RECV, DROP, DONE} state_t;

  state_t           state_q, state_d;
  logic [PTS_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bank_q, bank_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [PTS_W-1:0] pts_q, pts_d;
  logic             inv_q, inv_d;
  logic             wr_en_q, wr_en_d;
  logic [2:0]       wr_bank_q, wr_bank_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [DW-1:0]    wr_real_q, wr_real_d;
  logic [DW-1:0]    wr_imag_q, wr_imag_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             acc;
  logic             legal;
  logic             start;
  logic             wr;
  logic             last;
  logic [PTS_W-1:0] n;
  logic [PTS_W-1:0] p;
  logic [2:0]       wb;
  logic [AW-1:0]    wa;

  assign st_i.in_ready = sink_en_i & (state_q != DONE);
  assign acc           = st_i.in_valid & st_i.in_ready;
  assign legal         = (st_i.in_dftpts != '0) &&
                         (st_i.in_dftpts <= PTS_W'(MAX_PTS));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bank_d    = bank_q;
    addr_d    = addr_q;
    pts_d     = pts_q;
    inv_d     = inv_q;
    wr_en_d   = 1'b0;
    wr_bank_d = wr_bank_q;
    wr_addr_d = wr_addr_q;
    wr_real_d = wr_real_q;
    wr_imag_d = wr_imag_q;
    err_d     = 1'b0;
    done_d    = (state_q == DONE);
    start     = 1'b0;
    wr        = 1'b0;
    last      = 1'b0;
    n         = cnt_q;
    p         = pts_q;
    wb        = bank_q;
    wa        = addr_q;

    case (state_q)
      IDLE: if (acc) begin
        if (st_i.in_sop) start = 1'b1;
        else             err_d = 1'b1;
      end
      RECV: if (acc) begin
        if (st_i.in_sop) begin
          start = 1'b1;
          err_d = 1'b1;
        end else begin
          wr = 1'b1;
        end
      end
      DROP: if (acc && st_i.in_eop) state_d = IDLE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Every sop restarts the address generator, even when the frame is rejected.
    if (start) begin
      cnt_d  = '0;
      bank_d = '0;
      addr_d = '0;
      wb     = '0;
      wa     = '0;
      if (legal) begin
        pts_d = st_i.in_dftpts;
        inv_d = st_i.in_inverse;
        n     = '0;
        p     = st_i.in_dftpts;
        wr    = 1'b1;
      end else begin
        err_d   = 1'b1;
        state_d = st_i.in_eop ? IDLE : DROP;
      end
    end

    if (wr) begin
      wr_en_d   = 1'b1;
      wr_bank_d = wb;
      wr_addr_d = wa;
      wr_real_d = st_i.in_real;
      wr_imag_d = st_i.in_imag;
      cnt_d     = n + PTS_W'(1);
      if (wb == 3'(NBANK - 1)) begin
        bank_d = '0;
        addr_d = wa + AW'(1);
      end else begin
        bank_d = wb + 3'd1;
        addr_d = wa;
      end
      last = (n == p - PTS_W'(1));
      if (st_i.in_eop) begin
        if (last) begin
          state_d = DONE;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end else if (last) begin
        err_d   = 1'b1;
        state_d = DROP;
      end else begin
        state_d = RECV;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bank_q    <= '0;
      addr_q    <= '0;
      pts_q     <= '0;
      inv_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_bank_q <= '0;
      wr_addr_q <= '0;
      wr_real_q <= '0;
      wr_imag_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bank_q    <= bank_d;
      addr_q    <= addr_d;
      pts_q     <= pts_d;
      inv_q     <= inv_d;
      wr_en_q   <= wr_en_d;
      wr_bank_q <= wr_bank_d;
      wr_addr_q <= wr_addr_d;
      wr_real_q <= wr_real_d;
      wr_imag_q <= wr_imag_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign wr_en_o       = wr_en_q;
  assign wr_bank_o     = wr_bank_q;
  assign wr_addr_o     = wr_addr_q;
  assign wr_real_o     = wr_real_q;
  assign wr_imag_o     = wr_imag_q;
  assign frm_dftpts_o  = pts_q;
  assign frm_inverse_o = inv_q;
  assign frame_done_o  = done_q;
  assign frm_err_o     = err_q;

endmodule
